// File: rtl/segment_display_decode.sv
// Decodes a debounced pair of 7-segment glyphs back into an 8-bit count; flags and counts illegal glyphs.
// Commit lands STABLE_CYCLES edges after a pattern is first registered; no backpressure, the inputs are sampled every cycle.
module segment_display_decode #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [6:0] i_Segment1,
    input  logic [6:0] i_Segment2,
    output logic [7:0] o_Count,
    output logic       o_Valid,
    output logic       o_Locked,
    output logic       o_Error,
    output logic [7:0] o_Err_Count
);

    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

    // Returns {legal, nibble}; nibble is 0 when the glyph is not a hex digit.
    function automatic logic [4:0] glyph_to_nib(input logic [6:0] glyph);
        logic [4:0] res;
        case (glyph)
            7'h7E:   res = {1'b1, 4'h0};
            7'h30:   res = {1'b1, 4'h1};
            7'h6D:   res = {1'b1, 4'h2};
            7'h79:   res = {1'b1, 4'h3};
            7'h33:   res = {1'b1, 4'h4};
            7'h5B:   res = {1'b1, 4'h5};
            7'h5F:   res = {1'b1, 4'h6};
            7'h70:   res = {1'b1, 4'h7};
            7'h7F:   res = {1'b1, 4'h8};
            7'h7B:   res = {1'b1, 4'h9};
            7'h77:   res = {1'b1, 4'hA};
            7'h1F:   res = {1'b1, 4'hB};
            7'h4E:   res = {1'b1, 4'hC};
            7'h3D:   res = {1'b1, 4'hD};
            7'h4F:   res = {1'b1, 4'hE};
            7'h47:   res = {1'b1, 4'hF};
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

    logic [6:0] seg1_q, seg1_d;
    logic [6:0] seg2_q, seg2_d;
    logic [7:0] stab_q, stab_d;
    logic [7:0] count_q, count_d;
    logic       valid_q, valid_d;
    logic       locked_q, locked_d;
    logic       error_q, error_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       pair_same;
    logic       commit;
    logic [4:0] dec1;
    logic [4:0] dec2;

    assign pair_same = (i_Segment1 == seg1_q) && (i_Segment2 == seg2_q);
    assign commit    = pair_same && (stab_q == STAB_MAX - 8'd1);
    assign dec1      = glyph_to_nib(seg1_q);
    assign dec2      = glyph_to_nib(seg2_q);

    always_comb begin
        seg1_d    = seg1_q;
        seg2_d    = seg2_q;
        stab_d    = stab_q;
        count_d   = count_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        error_d   = 1'b0;
        err_cnt_d = err_cnt_q;

        if (!pair_same) begin
            seg1_d   = i_Segment1;
            seg2_d   = i_Segment2;
            stab_d   = 8'd0;
            locked_d = 1'b0;
        end else if (stab_q < STAB_MAX) begin
            stab_d = stab_q + 8'd1;
        end

        // Decision uses the registered pair, which equals the inputs whenever commit is set.
        if (commit) begin
            if (dec1[4] && dec2[4]) begin
                count_d  = {dec1[3:0], dec2[3:0]};
                valid_d  = 1'b1;
                locked_d = 1'b1;
            end else if ((seg1_q == 7'h00) && (seg2_q == 7'h00)) begin
                locked_d = 1'b0;
            end else begin
                error_d  = 1'b1;
                locked_d = 1'b0;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            seg1_q    <= 7'h00;
            seg2_q    <= 7'h00;
            stab_q    <= 8'd0;
            count_q   <= 8'h00;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            seg1_q    <= seg1_d;
            seg2_q    <= seg2_d;
            stab_q    <= stab_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_Count     = count_q;
    assign o_Valid     = valid_q;
    assign o_Locked    = locked_q;
    assign o_Error     = error_q;
    assign o_Err_Count = err_cnt_q;

endmodule

// File: tb/tb_segment_display_decode.sv
// Directed bench for segment_display_decode: expected commits are queued when a pattern is
// driven and popped by a pulse monitor; directed checks cover latency, lock and reset behaviour.
module tb_segment_display_decode;

    localparam int S = 4;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg1;
    logic [6:0] seg2;
    logic [7:0] o_count;
    logic       o_valid;
    logic       o_locked;
    logic       o_error;
    logic [7:0] o_err_count;

    segment_display_decode #(.STABLE_CYCLES(S)) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Segment1  (seg1),
        .i_Segment2  (seg2),
        .o_Count     (o_count),
        .o_Valid     (o_valid),
        .o_Locked    (o_locked),
        .o_Error     (o_error),
        .o_Err_Count (o_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] count;
        logic [7:0] err_cnt;
    } exp_t;

    exp_t sb[$];

    logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int         checks = 0;
    int         errors = 0;
    int         n_err_seen = 0;
    int         n_err_exp = 0;
    logic [6:0] prev1 = 7'h00;
    logic [6:0] prev2 = 7'h00;
    logic [7:0] exp_cnt = 8'h00;
    logic [7:0] exp_err = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nib_of(input logic [6:0] g);
        for (int i = 0; i < 16; i++) begin
            if (glyph_tab[i] == g) return i;
        end
        return -1;
    endfunction

    // Drive a new pair; hold is how many edges it will stay. A commit needs S+1 edges.
    task automatic apply(input logic [6:0] a, input logic [6:0] b, input int hold);
        int n1;
        int n2;
        exp_t e;
        seg1 = a;
        seg2 = b;
        if (((a != prev1) || (b != prev2)) && (hold >= S + 1)) begin
            n1 = nib_of(a);
            n2 = nib_of(b);
            if ((n1 >= 0) && (n2 >= 0)) begin
                exp_cnt = 8'((n1 << 4) | n2);
                e = '{is_err: 1'b0, count: exp_cnt, err_cnt: exp_err};
                sb.push_back(e);
            end else if ((a != 7'h00) || (b != 7'h00)) begin
                if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
                n_err_exp++;
                e = '{is_err: 1'b1, count: exp_cnt, err_cnt: exp_err};
                sb.push_back(e);
            end
        end
        prev1 = a;
        prev2 = b;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("valid_error_exclusive", {31'd0, o_valid & o_error}, 32'd0);
        if (o_error === 1'b1) n_err_seen++;
        if ((o_valid === 1'b1) || (o_error === 1'b1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, o_valid, o_error}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind_error", {31'd0, o_error}, {31'd0, e.is_err});
                chk("pulse_count", {24'd0, o_count}, {24'd0, e.count});
                chk("pulse_err_count", {24'd0, o_err_count}, {24'd0, e.err_cnt});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        seg1  = 7'h00;
        seg2  = 7'h00;
        #2;
        chk("rst_count", {24'd0, o_count}, 32'h00);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_locked", {31'd0, o_locked}, 32'd0);
        chk("rst_error", {31'd0, o_error}, 32'd0);
        chk("rst_err_count", {24'd0, o_err_count}, 32'h00);
        tick(2);
        rst_n = 1'b1;

        // Legal pair 2/5: commit exactly S edges after first registration.
        apply(7'h6D, 7'h5B, 10);
        tick(S);
        chk("t1_no_early_valid", {31'd0, o_valid}, 32'd0);
        chk("t1_no_early_count", {24'd0, o_count}, 32'h00);
        tick(1);
        chk("t1_valid", {31'd0, o_valid}, 32'd1);
        chk("t1_count", {24'd0, o_count}, 32'h25);
        chk("t1_locked", {31'd0, o_locked}, 32'd1);
        tick(1);
        chk("t1_valid_one_cycle", {31'd0, o_valid}, 32'd0);
        chk("t1_still_locked", {31'd0, o_locked}, 32'd1);
        tick(4);

        // Illegal high digit.
        apply(7'h01, 7'h7E, 6);
        tick(S + 1);
        chk("t3_error", {31'd0, o_error}, 32'd1);
        chk("t3_err_count", {24'd0, o_err_count}, 32'd1);
        chk("t3_count_held", {24'd0, o_count}, 32'h25);
        chk("t3_locked", {31'd0, o_locked}, 32'd0);
        tick(1);

        // Short glitch of 1/0 must not commit; F/b then commits.
        apply(7'h30, 7'h7E, 2);
        tick(2);
        apply(7'h47, 7'h1F, 10);
        tick(S);
        chk("t2_no_glitch_commit", {24'd0, o_count}, 32'h25);
        tick(1);
        chk("t2_count", {24'd0, o_count}, 32'hFB);
        chk("t2_valid", {31'd0, o_valid}, 32'd1);
        tick(5);

        // Same value recommitted still pulses.
        apply(7'h7E, 7'h7E, 1);
        tick(1);
        apply(7'h47, 7'h1F, 6);
        tick(S + 1);
        chk("recommit_valid", {31'd0, o_valid}, 32'd1);
        chk("recommit_count", {24'd0, o_count}, 32'hFB);
        tick(1);

        // Blank pair: lock drops at the first edge, nothing commits.
        apply(7'h00, 7'h00, 20);
        tick(1);
        chk("t4_lock_drop", {31'd0, o_locked}, 32'd0);
        chk("t4_count_kept", {24'd0, o_count}, 32'hFB);
        tick(19);
        chk("t4_locked", {31'd0, o_locked}, 32'd0);
        chk("t4_err_count", {24'd0, o_err_count}, 32'd1);

        // Back-to-back error runs; change lands on each commit edge.
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) apply(7'h01, 7'h01, 5);
            else            apply(7'h02, 7'h02, 5);
            tick(5);
        end
        tick(1);
        chk("t5_err_saturated", {24'd0, o_err_count}, 32'd255);
        chk("t5_err_pulses", n_err_seen, n_err_exp);
        chk("t5_count_kept", {24'd0, o_count}, 32'hFB);

        // Reset mid-run at stab=2.
        apply(7'h7F, 7'h7F, 3);
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", {24'd0, o_count}, 32'h00);
        chk("t6_rst_err_count", {24'd0, o_err_count}, 32'h00);
        chk("t6_rst_locked", {31'd0, o_locked}, 32'd0);
        chk("t6_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("t6_rst_error", {31'd0, o_error}, 32'd0);
        exp_cnt = 8'h00;
        exp_err = 8'h00;
        prev1   = 7'h00;
        prev2   = 7'h00;
        tick(1);
        rst_n = 1'b1;
        apply(7'h7F, 7'h7F, 10);
        tick(S);
        chk("t6_no_early_valid", {31'd0, o_valid}, 32'd0);
        chk("t6_no_early_count", {24'd0, o_count}, 32'h00);
        tick(1);
        chk("t6_count", {24'd0, o_count}, 32'h88);
        chk("t6_valid", {31'd0, o_valid}, 32'd1);
        chk("t6_locked", {31'd0, o_locked}, 32'd1);
        tick(5);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
